// File: rtl/mem_access_unit_pkg.sv
// Shared decode for the MEM-stage load/store engine: MIPS opcodes, FSM states,
// access-size decode and alignment rules.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_t;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic size_t op_size(input logic [5:0] op);
    size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LW, OP_SW:         sz = SZ_WORD;
      default:              sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic op_misaligned(input size_t sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Little-endian lane extraction of a RAM word with sign/zero extension for
// lb/lh/lbu/lhu; lw passes the word through.
module load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [5:0]  op,
  output logic [31:0] rdata
);

  size_t       w_size;
  logic        w_sext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size = op_size(op);
    w_sext = (op == OP_LB) || (op == OP_LH);
    case (off)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = off[1] ? word[31:16] : word[15:0];
    case (w_size)
      SZ_BYTE: rdata = {{24{w_sext & w_byte[7]}}, w_byte};
      SZ_HALF: rdata = {{16{w_sext & w_half[15]}}, w_half};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store engine between the MEM stage and a word-wide
// synchronous RAM with byte enables; one request in flight at a time.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 8
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [5:0]    op,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output state_t        o_state
);

  // Handshake: req is held high until the one-cycle done pulse; stall tells the
  // pipeline to hold MEM for exactly that window. A new req is sampled only in IDLE.

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t          r_state;
  logic [2:0]      r_cnt;
  logic [5:0]      r_op;
  logic [1:0]      r_off;
  logic            r_is_store;
  logic            r_done;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic            r_ram_en;
  logic [3:0]      r_ram_we;
  logic [AW-1:0]   r_ram_addr;
  logic [31:0]     r_ram_wdata;

  logic            w_load;
  logic            w_store;
  logic            w_bad;
  size_t           w_size;
  logic [3:0]      w_st_we;
  logic [31:0]     w_st_wdata;
  logic [31:0]     w_ext;
  logic            w_unused;

  assign w_load   = op_is_load(op);
  assign w_store  = op_is_store(op);
  assign w_size   = op_size(op);
  assign w_bad    = ~(w_load | w_store) | op_misaligned(w_size, addr[1:0]);
  assign w_unused = ^addr[31:AW+2];

  // Store lanes are steered from the live request so the RAM strobes can be
  // registered on the same edge that accepts it.
  always_comb begin
    w_st_we    = 4'b0000;
    w_st_wdata = wdata;
    case (w_size)
      SZ_BYTE: begin
        w_st_we    = 4'b0001 << addr[1:0];
        w_st_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        w_st_we    = addr[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{wdata[15:0]}};
      end
      SZ_WORD: w_st_we = 4'b1111;
      default: w_st_we = 4'b0000;
    endcase
    if (!w_store) w_st_we = 4'b0000;
  end

  load_extend u_load_extend (
    .word  (ram_rdata),
    .off   (r_off),
    .op    (r_op),
    .rdata (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_op        <= 6'd0;
      r_off       <= 2'd0;
      r_is_store  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 4'b0000;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_op       <= op;
            r_off      <= addr[1:0];
            r_is_store <= w_store;
            if (w_bad) begin
              r_state <= ST_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= 32'd0;
            end else begin
              r_state     <= ST_ACCESS;
              r_ram_en    <= 1'b1;
              r_ram_we    <= w_st_we;
              r_ram_addr  <= addr[AW+1:2];
              r_ram_wdata <= w_st_wdata;
            end
          end
        end
        ST_ACCESS: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 4'b0000;
          if (r_is_store) begin
            r_state <= ST_RESP;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= LAT_INIT;
          end
        end
        ST_WAIT: begin
          // Count of 1 marks the cycle in which ram_rdata holds this load's word.
          if (r_cnt <= 3'd1) begin
            r_cnt   <= 3'd0;
            r_rdata <= w_ext;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall     = req & ~r_done;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign o_state   = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: unit 0 (RD_LAT=1) runs directed vectors through a
// scoreboard; unit 1 (RD_LAT=3) checks long-latency timing.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req       [N];
  logic [5:0]  op        [N];
  logic [31:0] addr      [N];
  logic [31:0] wdata     [N];
  logic        stall     [N];
  logic        done      [N];
  logic [31:0] rdata     [N];
  logic        err       [N];
  logic        ram_en    [N];
  logic [3:0]  ram_we    [N];
  logic [7:0]  ram_addr  [N];
  logic [31:0] ram_wdata [N];
  logic [31:0] ram_rdata [N];
  state_t      st        [N];

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // {lat[7:0], err, rdata[31:0]} and {is_load, ram_addr[7:0], we[3:0], wdata[31:0]}
  logic [40:0] exp_q[$];
  int          t_q[$];
  logic [44:0] ram_q[$];
  int          rt_q[$];

  logic [40:0] m_e;
  logic [44:0] m_r;
  int          m_t;
  int          m_rt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- DUTs and RAM models ----------------
  for (genvar g = 0; g < N; g++) begin : g_u
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];

    mem_access_unit #(.RD_LAT(LAT), .AW(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req[g]),
      .op        (op[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .stall     (stall[g]),
      .done      (done[g]),
      .rdata     (rdata[g]),
      .err       (err[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g]),
      .o_state   (st[g])
    );

    // Read data is valid exactly LAT edges after the ram_en cycle, junk otherwise.
    always @(posedge clk) begin
      if (ram_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[g][b]) mem[ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
      end
      if (ram_en[g] && ram_we[g] == 4'b0000) pipe[0] <= mem[ram_addr[g]];
      else                                   pipe[0] <= 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata[g] = pipe[LAT-1];
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver (unit 0) ----------------
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic e, input int lat,
                       input logic [3:0] we, input logic [31:0] rwd);
    bit seen     = 1'b0;
    bit stall_ok = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b1; op[0] = o; addr[0] = a; wdata[0] = d;
    exp_q.push_back({8'(lat), e, rd});
    t_q.push_back(cyc);
    if (!e) begin
      ram_q.push_back({(we == 4'b0000), a[9:2], we, rwd});
      rt_q.push_back(cyc);
    end
    for (int n = 0; n < 16 && !seen; n++) begin
      @(negedge clk);
      if (done[0]) begin
        seen = 1'b1;
        if (stall[0]) stall_ok = 1'b0;
      end else if (!stall[0]) begin
        stall_ok = 1'b0;
      end
    end
    check("done_seen", 64'(seen), 64'(1));
    check("stall_window", 64'(stall_ok), 64'(1));
    @(posedge clk); #1;
    req[0] = 1'b0;
  endtask

  // ---------------- unit 1 (RD_LAT=3) directed ----------------
  task automatic run1(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input int lat);
    bit seen     = 1'b0;
    bit stall_ok = 1'b1;
    int pulses   = 0;
    int t0;
    int td       = 0;
    @(posedge clk); #1;
    req[1] = 1'b1; op[1] = o; addr[1] = a; wdata[1] = d;
    t0 = cyc;
    for (int n = 0; n < 16 && !seen; n++) begin
      @(negedge clk);
      if (ram_en[1]) pulses++;
      if (done[1]) begin
        seen = 1'b1;
        td   = cyc;
      end else if (!stall[1]) begin
        stall_ok = 1'b0;
      end
    end
    check("u1_done_seen", 64'(seen), 64'(1));
    check("u1_done_latency", 64'(td - t0), 64'(lat));
    check("u1_ram_en_pulses", 64'(pulses), 64'(1));
    check("u1_stall_window", 64'(stall_ok), 64'(1));
    check("u1_rdata", 64'(rdata[1]), 64'(rd));
    check("u1_err", 64'(err[1]), 64'(0));
    @(posedge clk); #1;
    req[1] = 1'b0;
  endtask

  // ---------------- monitor / scoreboard (unit 0) ----------------
  always @(negedge clk) begin
    if (done[0]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done[0]), 64'(0));
      end else begin
        m_e = exp_q.pop_front();
        m_t = t_q.pop_front();
        check("rdata", 64'(rdata[0]), 64'(m_e[31:0]));
        check("err", 64'(err[0]), 64'(m_e[32]));
        check("done_latency", 64'(cyc - m_t), 64'(m_e[40:33]));
      end
    end
    if (ram_en[0]) begin
      if (ram_q.size() == 0) begin
        check("unexpected_ram_en", 64'(ram_en[0]), 64'(0));
      end else begin
        m_r  = ram_q.pop_front();
        m_rt = rt_q.pop_front();
        check("ram_en_latency", 64'(cyc - m_rt), 64'(1));
        check("ram_addr", 64'(ram_addr[0]), 64'(m_r[43:36]));
        check("ram_we", 64'(ram_we[0]), 64'(m_r[35:32]));
        if (!m_r[44]) check("ram_wdata", 64'(ram_wdata[0]), 64'(m_r[31:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    for (int u = 0; u < N; u++) begin
      req[u] = 1'b0; op[u] = 6'd0; addr[u] = 32'd0; wdata[u] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(st[0]), 64'(ST_IDLE));
    check("rst_done", 64'(done[0]), 64'(0));
    check("rst_err", 64'(err[0]), 64'(0));
    check("rst_rdata", 64'(rdata[0]), 64'(0));
    check("rst_ram_en", 64'(ram_en[0]), 64'(0));
    check("rst_ram_we", 64'(ram_we[0]), 64'(0));
    check("rst_stall", 64'(stall[0]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    //    op      addr          wdata         exp rdata     err lat we       ram wdata
    issue(OP_SW,  32'h10,       32'h12345678, 32'h0,        0,  2,  4'b1111, 32'h12345678);
    issue(OP_LW,  32'h10,       32'h0,        32'h12345678, 0,  3,  4'b0000, 32'h0);
    issue(OP_SB,  32'h13,       32'h555555AB, 32'h12345678, 0,  2,  4'b1000, 32'hABABABAB);
    issue(OP_LB,  32'h13,       32'h0,        32'hFFFFFFAB, 0,  3,  4'b0000, 32'h0);
    issue(OP_LBU, 32'h13,       32'h0,        32'h000000AB, 0,  3,  4'b0000, 32'h0);
    issue(OP_SH,  32'h16,       32'h12348001, 32'h000000AB, 0,  2,  4'b1100, 32'h80018001);
    issue(OP_LH,  32'h16,       32'h0,        32'hFFFF8001, 0,  3,  4'b0000, 32'h0);
    issue(OP_LHU, 32'h16,       32'h0,        32'h00008001, 0,  3,  4'b0000, 32'h0);
    issue(OP_SB,  32'h11,       32'h0000007F, 32'h00008001, 0,  2,  4'b0010, 32'h7F7F7F7F);
    issue(OP_LB,  32'h11,       32'h0,        32'h0000007F, 0,  3,  4'b0000, 32'h0);
    issue(OP_LH,  32'h10,       32'h0,        32'h00007F78, 0,  3,  4'b0000, 32'h0);
    issue(OP_LW,  32'h1010,     32'h0,        32'hAB347F78, 0,  3,  4'b0000, 32'h0);
    issue(OP_SW,  32'h3FC,      32'hFFFF0000, 32'hAB347F78, 0,  2,  4'b1111, 32'hFFFF0000);
    issue(OP_LH,  32'h3FE,      32'h0,        32'hFFFFFFFF, 0,  3,  4'b0000, 32'h0);
    issue(OP_LHU, 32'h3FC,      32'h0,        32'h00000000, 0,  3,  4'b0000, 32'h0);
    issue(OP_LW,  32'h10,       32'h0,        32'hAB347F78, 0,  3,  4'b0000, 32'h0);
    issue(OP_LW,  32'h02,       32'h0,        32'h0,        1,  1,  4'b0000, 32'h0);
    issue(OP_LHU, 32'h16,       32'h0,        32'h00008001, 0,  3,  4'b0000, 32'h0);
    issue(OP_SH,  32'h05,       32'h1234,     32'h0,        1,  1,  4'b0000, 32'h0);
    issue(OP_LW,  32'h10,       32'h0,        32'hAB347F78, 0,  3,  4'b0000, 32'h0);
    issue(6'h00,  32'h10,       32'h0,        32'h0,        1,  1,  4'b0000, 32'h0);
    issue(OP_LW,  32'h13,       32'h0,        32'h0,        1,  1,  4'b0000, 32'h0);
    issue(OP_LB,  32'h13,       32'h0,        32'hFFFFFFAB, 0,  3,  4'b0000, 32'h0);

    run1(OP_SW, 32'h40, 32'hCAFEF00D, 32'h0,        2);
    run1(OP_LW, 32'h40, 32'h0,        32'hCAFEF00D, 5);

    // Reset during the WAIT cycle of a load on unit 0.
    @(posedge clk); #1;
    req[0] = 1'b1; op[0] = OP_LW; addr[0] = 32'h10; wdata[0] = 32'h0;
    ram_q.push_back({1'b1, 8'h04, 4'b0000, 32'h0});
    rt_q.push_back(cyc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_rst_in_wait", 64'(st[0]), 64'(ST_WAIT));
    rst = 1'b0;
    req[0] = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_state", 64'(st[0]), 64'(ST_IDLE));
    check("mid_rst_done", 64'(done[0]), 64'(0));
    check("mid_rst_rdata", 64'(rdata[0]), 64'(0));
    check("mid_rst_ram_en", 64'(ram_en[0]), 64'(0));
    rst = 1'b1;

    issue(OP_SW, 32'h20, 32'h0BADF00D, 32'h0,        0, 2, 4'b1111, 32'h0BADF00D);
    issue(OP_LW, 32'h20, 32'h0,        32'h0BADF00D, 0, 3, 4'b0000, 32'h0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("ram_q_drained", 64'(ram_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
